obi_ascon_stream: RTL and testbench

- Second-generation OBI slave front-end for the ASCON controller.
- Replaces direct register handoff with parametrised input/output data FIFOs, a readable register map, and a maskable, sticky, write-1-to-clear interrupt.
- Sits between the system OBI crossbar and the ascon_controller core.
- Software streams words into the input FIFO; the core consumes them via valid/ready and returns results through the output FIFO.

---
 rtl/obi_ascon_stream.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_obi_ascon_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/obi_ascon_stream.sv
// obi_ascon_stream: OBI slave front-end for the ASCON controller core.
// Software streams data words into an input FIFO and drains results from an
// output FIFO. Key, nonce, control, status and a sticky interrupt are exposed
// as a small register map.
module obi_ascon_stream #(
  parameter int unsigned CCW       = 64,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned AW        = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_i,
  output logic           gnt_o,
  input  logic [AW-1:0]  addr_i,
  input  logic           we_i,
  input  logic [3:0]     be_i,
  input  logic [31:0]    wdata_i,
  input  logic           aid_i,
  output logic           rvalid_o,
  output logic [31:0]    rdata_o,
  output logic           rid_o,
  output logic           err_o,
  output logic [127:0]   key_o,
  output logic [127:0]   nonce_o,
  output logic           start_o,
  output logic           mode_o,
  output logic [CCW-1:0] din_o,
  output logic           din_valid_o,
  input  logic           din_ready_i,
  input  logic [CCW-1:0] dout_i,
  input  logic           dout_valid_i,
  output logic           dout_ready_o,
  input  logic           busy_i,
  input  logic           done_i,
  input  logic           auth_i,
  output logic           irq_o
);

  localparam int unsigned IN_PW  = $clog2(IN_DEPTH);
  localparam int unsigned OUT_PW = $clog2(OUT_DEPTH);

  localparam logic [AW-1:0] A_CTRL    = AW'('h00);
  localparam logic [AW-1:0] A_STATUS  = AW'('h04);
  localparam logic [AW-1:0] A_IRQ_EN  = AW'('h08);
  localparam logic [AW-1:0] A_IRQ_ST  = AW'('h0C);
  localparam logic [AW-1:0] A_DIN_LO  = AW'('h30);
  localparam logic [AW-1:0] A_DIN_HI  = AW'('h34);
  localparam logic [AW-1:0] A_DOUT_LO = AW'('h38);
  localparam logic [AW-1:0] A_DOUT_HI = AW'('h3C);
  localparam logic [AW-1:0] A_LEVEL   = AW'('h40);

  // Register state
  logic [127:0] key_q, nonce_q;
  logic [2:0]   irq_en_q, irq_st_q, irq_set, irq_clr;
  logic         start_q, mode_q, done_seen_q, auth_ok_q, irq_q, ready_q;
  logic         rvalid_q, rid_q, err_q;
  logic [31:0]  rdata_q;

  // Bus decode results
  logic        resp_err, ctrl_wr, key_wr, nonce_wr, irq_en_wr, stage_wr;
  logic [31:0] rd_data;
  logic [1:0]  word_idx;
  logic        sel_key, sel_nonce;

  // FIFO state
  logic [CCW-1:0]    in_mem [IN_DEPTH];
  logic [IN_PW-1:0]  in_wr_ptr, in_rd_ptr;
  logic [IN_PW:0]    in_cnt;
  logic              in_push, in_pop, in_full, in_empty;
  logic [CCW-1:0]    in_push_data;

  logic [CCW-1:0]    out_mem [OUT_DEPTH];
  logic [OUT_PW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OUT_PW:0]   out_cnt;
  logic              out_push, out_pop, out_full, out_empty;
  logic [CCW-1:0]    out_head;
  logic [31:0]       out_head_lo, out_head_hi;

  logic [6:0]        status;

  assign gnt_o    = req_i;
  assign word_idx = addr_i[3:2];
  assign sel_key   = (addr_i[AW-1:4] == (AW-4)'(1)) && (addr_i[1:0] == 2'b00);
  assign sel_nonce = (addr_i[AW-1:4] == (AW-4)'(2)) && (addr_i[1:0] == 2'b00);

  assign in_empty    = (in_cnt == '0);
  assign in_full     = (in_cnt == (IN_PW+1)'(IN_DEPTH));
  assign din_valid_o = !in_empty;
  assign din_o       = in_empty ? '0 : in_mem[in_rd_ptr];
  assign in_pop      = din_valid_o & din_ready_i;

  assign out_empty    = (out_cnt == '0);
  assign out_full     = (out_cnt == (OUT_PW+1)'(OUT_DEPTH));
  assign dout_ready_o = ready_q & !out_full;
  assign out_push     = dout_valid_i & dout_ready_o;
  assign out_head     = out_empty ? '0 : out_mem[out_rd_ptr];

  assign status  = {auth_ok_q, done_seen_q, out_full, out_empty, in_full, in_empty, busy_i};
  assign irq_set = {out_push & out_empty, done_i & ~auth_i & mode_q, done_i};

  assign key_o    = key_q;
  assign nonce_o  = nonce_q;
  assign start_o  = start_q;
  assign mode_o   = mode_q;
  assign irq_o    = irq_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign err_o    = err_q;

  // 64-bit words travel as two 32-bit halves; a staging register holds DIN_LO
  if (CCW == 64) begin : g_wide
    logic [31:0] stage_q;
    // Capture the low half until the matching DIN_HI write pushes the word
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stage_q <= '0;
      else if (stage_wr) stage_q <= wdata_i;
    end
    assign in_push_data = {wdata_i, stage_q};
    assign out_head_lo  = out_head[31:0];
    assign out_head_hi  = out_head[63:32];
  end else begin : g_narrow
    assign in_push_data = wdata_i;
    assign out_head_lo  = out_head[31:0];
    assign out_head_hi  = '0;
  end

  // Decode the current request into read data, error flag and side effects
  always_comb begin
    resp_err  = 1'b0;
    rd_data   = '0;
    ctrl_wr   = 1'b0;
    key_wr    = 1'b0;
    nonce_wr  = 1'b0;
    irq_en_wr = 1'b0;
    irq_clr   = '0;
    stage_wr  = 1'b0;
    in_push   = 1'b0;
    out_pop   = 1'b0;
    if (req_i) begin
      if (addr_i == A_CTRL) begin
        if (we_i) begin
          if (be_i != 4'hF || busy_i) resp_err = 1'b1;
          else ctrl_wr = 1'b1;
        end
      end else if (addr_i == A_STATUS) begin
        if (!we_i) rd_data = {25'd0, status};
      end else if (addr_i == A_IRQ_EN) begin
        if (we_i) irq_en_wr = 1'b1;
        else rd_data = {29'd0, irq_en_q};
      end else if (addr_i == A_IRQ_ST) begin
        if (we_i) irq_clr = wdata_i[2:0] & {3{be_i[0]}};
        else rd_data = {29'd0, irq_st_q};
      end else if (sel_key) begin
        if (we_i) begin
          if (busy_i) resp_err = 1'b1;
          else key_wr = 1'b1;
        end else rd_data = key_q[word_idx*32 +: 32];
      end else if (sel_nonce) begin
        if (we_i) begin
          if (busy_i) resp_err = 1'b1;
          else nonce_wr = 1'b1;
        end else rd_data = nonce_q[word_idx*32 +: 32];
      end else if (addr_i == A_DIN_LO) begin
        if (we_i) begin
          if (be_i != 4'hF) resp_err = 1'b1;
          else if (CCW == 64) stage_wr = 1'b1;
          else if (in_full) resp_err = 1'b1;
          else in_push = 1'b1;
        end
      end else if (addr_i == A_DIN_HI) begin
        if (CCW != 64) resp_err = 1'b1;
        else if (we_i) begin
          if (be_i != 4'hF || in_full) resp_err = 1'b1;
          else in_push = 1'b1;
        end
      end else if (addr_i == A_DOUT_LO) begin
        if (!we_i) begin
          if (CCW == 64) rd_data = out_head_lo;
          else if (out_empty) resp_err = 1'b1;
          else begin
            out_pop = 1'b1;
            rd_data = out_head_lo;
          end
        end
      end else if (addr_i == A_DOUT_HI) begin
        if (CCW != 64) resp_err = 1'b1;
        else if (!we_i) begin
          if (out_empty) resp_err = 1'b1;
          else begin
            out_pop = 1'b1;
            rd_data = out_head_hi;
          end
        end
      end else if (addr_i == A_LEVEL) begin
        if (!we_i) rd_data = {16'(out_cnt), 16'(in_cnt)};
      end else begin
        resp_err = 1'b1;
      end
      if (resp_err) rd_data = '0;
    end
  end

  // Registered OBI response, one per granted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      if (req_i) begin
        rdata_q <= rd_data;
        rid_q   <= aid_i;
        err_q   <= resp_err;
      end
    end
  end

  // Key, nonce and interrupt-enable registers with bytewise writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q    <= '0;
      nonce_q  <= '0;
      irq_en_q <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (key_wr && be_i[b])   key_q[word_idx*32 + b*8 +: 8]   <= wdata_i[b*8 +: 8];
        if (nonce_wr && be_i[b]) nonce_q[word_idx*32 + b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
      if (irq_en_wr && be_i[0]) irq_en_q <= wdata_i[2:0];
    end
  end

  // Start pulse, mode latch, completion status and sticky interrupt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q     <= 1'b0;
      mode_q      <= 1'b0;
      done_seen_q <= 1'b0;
      auth_ok_q   <= 1'b0;
      irq_st_q    <= '0;
      irq_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      start_q <= ctrl_wr & wdata_i[0];
      if (ctrl_wr && wdata_i[0]) begin
        mode_q      <= wdata_i[1];
        done_seen_q <= 1'b0;
        auth_ok_q   <= 1'b0;
      end
      if (done_i) begin
        done_seen_q <= 1'b1;
        auth_ok_q   <= auth_i;
      end
      irq_st_q <= (irq_st_q & ~irq_clr) | irq_set;
      irq_q    <= |(irq_st_q & irq_en_q);
    end
  end

  // Input FIFO storage; contents need no reset since din_o is gated by count
  always_ff @(posedge clk_i) begin
    if (in_push) in_mem[in_wr_ptr] <= in_push_data;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_cnt    <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
      if (in_push && !in_pop)      in_cnt <= in_cnt + 1'b1;
      else if (!in_push && in_pop) in_cnt <= in_cnt - 1'b1;
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk_i) begin
    if (out_push) out_mem[out_wr_ptr] <= dout_i;
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      if (out_push && !out_pop)      out_cnt <= out_cnt + 1'b1;
      else if (!out_push && out_pop) out_cnt <= out_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_ascon_stream.sv
// tb_obi_ascon_stream: directed bench for obi_ascon_stream (CCW=64, depth 4).
module tb_obi_ascon_stream;

  localparam int CCW = 64;
  localparam int AW  = 8;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b1;
  logic           req_i = 1'b0, we_i = 1'b0, aid_i = 1'b0;
  logic [AW-1:0]  addr_i = '0;
  logic [3:0]     be_i = '0;
  logic [31:0]    wdata_i = '0;
  logic           gnt_o, rvalid_o, rid_o, err_o;
  logic [31:0]    rdata_o;
  logic [127:0]   key_o, nonce_o;
  logic           start_o, mode_o, din_valid_o, dout_ready_o, irq_o;
  logic [CCW-1:0] din_o;
  logic           din_ready_i = 1'b0, dout_valid_i = 1'b0;
  logic [CCW-1:0] dout_i = '0;
  logic           busy_i = 1'b0, done_i = 1'b0, auth_i = 1'b0;

  int checks = 0;
  int passes = 0;

  logic        rsp_valid, rsp_err, rsp_id, rsp_gnt, cur_aid = 1'b0;
  logic [31:0] rsp_data;
  logic [127:0] key_c   = 128'h000102030405060708090A0B0C0D0E0F;
  logic [127:0] nonce_c = 128'h101112131415161718191A1B1C1D1E1F;
  logic [63:0]  x0 = 64'h1111_2222_3333_4444;
  logic [63:0]  x1 = 64'h5555_6666_7777_8888;

  obi_ascon_stream #(.CCW(CCW), .IN_DEPTH(4), .OUT_DEPTH(4), .AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o), .key_o(key_o), .nonce_o(nonce_o),
    .start_o(start_o), .mode_o(mode_o), .din_o(din_o), .din_valid_o(din_valid_o),
    .din_ready_i(din_ready_i), .dout_i(dout_i), .dout_valid_i(dout_valid_i),
    .dout_ready_o(dout_ready_o), .busy_i(busy_i), .done_i(done_i), .auth_i(auth_i),
    .irq_o(irq_o)
  );

  // Free-running clock, active edge is posedge
  always #5 clk_i = ~clk_i;

  // Safety net so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One OBI transaction: drive on a negedge, capture the response a cycle later
  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [3:0] b,
                               input logic [31:0] d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
    cur_aid = ~cur_aid; aid_i = cur_aid;
    #1 rsp_gnt = gnt_o;
    @(negedge clk_i);
    rsp_valid = rvalid_o; rsp_data = rdata_o; rsp_err = err_o; rsp_id = rid_o;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
  endtask

  task automatic checkResp(input string tag, input logic exp_err, input logic [31:0] exp_data);
    checkOutput({tag, ".gnt"}, 128'(rsp_gnt), 128'(1'b1));
    checkOutput({tag, ".rvalid"}, 128'(rsp_valid), 128'(1'b1));
    checkOutput({tag, ".rid"}, 128'(rsp_id), 128'(cur_aid));
    checkOutput({tag, ".err"}, 128'(rsp_err), 128'(exp_err));
    checkOutput({tag, ".rdata"}, 128'(rsp_data), 128'(exp_data));
  endtask

  initial begin
    // Reset state
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst.rvalid", 128'(rvalid_o), 128'(0));
    checkOutput("rst.irq", 128'(irq_o), 128'(0));
    checkOutput("rst.start", 128'(start_o), 128'(0));
    checkOutput("rst.din_valid", 128'(din_valid_o), 128'(0));
    checkOutput("rst.dout_ready", 128'(dout_ready_o), 128'(0));
    checkOutput("rst.key", key_o, 128'(0));
    rst_ni = 1'b1;
    #1 checkOutput("rst.dout_ready_at_release", 128'(dout_ready_o), 128'(0));
    @(negedge clk_i);
    checkOutput("rst.dout_ready_after", 128'(dout_ready_o), 128'(1));

    // STATUS after reset: in_empty and out_empty only; unmapped address errors
    applyStimulus(1'b0, 8'h04, 4'h0, 32'h0); checkResp("status_rst", 1'b0, 32'h0000_000A);
    applyStimulus(1'b0, 8'h50, 4'h0, 32'h0); checkResp("unmapped", 1'b1, 32'h0);

    // Key and nonce write and read-back
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i*4), 4'hF, key_c[i*32 +: 32]);   checkResp("key_wr", 1'b0, 32'h0);
      applyStimulus(1'b1, 8'(8'h20 + i*4), 4'hF, nonce_c[i*32 +: 32]); checkResp("nonce_wr", 1'b0, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'(8'h10 + i*4), 4'h0, 32'h0); checkResp("key_rd", 1'b0, key_c[i*32 +: 32]);
      applyStimulus(1'b0, 8'(8'h20 + i*4), 4'h0, 32'h0); checkResp("nonce_rd", 1'b0, nonce_c[i*32 +: 32]);
    end
    checkOutput("key_o", key_o, key_c);
    checkOutput("nonce_o", nonce_o, nonce_c);

    // Key write while busy is rejected and leaves the key intact
    busy_i = 1'b1;
    applyStimulus(1'b1, 8'h10, 4'hF, 32'hDEAD_BEEF); checkResp("key_busy", 1'b1, 32'h0);
    busy_i = 1'b0;
    checkOutput("key_o_busy", key_o, key_c);

    // Start encrypt: one-cycle pulse
    applyStimulus(1'b1, 8'h00, 4'hF, 32'h1); checkResp("ctrl_start", 1'b0, 32'h0);
    checkOutput("start_hi", 128'(start_o), 128'(1));
    checkOutput("mode_enc", 128'(mode_o), 128'(0));
    @(negedge clk_i);
    checkOutput("start_lo", 128'(start_o), 128'(0));

    // Fill the input FIFO with the core stalled
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h30, 4'hF, 32'hA000_0000 + i); checkResp("din_lo", 1'b0, 32'h0);
      applyStimulus(1'b1, 8'h34, 4'hF, 32'hB000_0000 + i); checkResp("din_hi", 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("level_full", 1'b0, 32'h0000_0004);
    applyStimulus(1'b0, 8'h04, 4'h0, 32'h0); checkResp("status_full", 1'b0, 32'h0000_000C);
    checkOutput("din_head0", din_o, 128'(64'hB000_0000_A000_0000));
    applyStimulus(1'b1, 8'h30, 4'hF, 32'hA000_0009); checkResp("din_lo5", 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h34, 4'hF, 32'hB000_0009); checkResp("din_hi5", 1'b1, 32'h0);
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("level_after_err", 1'b0, 32'h0000_0004);

    // Core consumes one word, then drains the rest
    @(negedge clk_i); din_ready_i = 1'b1;
    @(negedge clk_i); din_ready_i = 1'b0;
    checkOutput("din_head1", din_o, 128'(64'hB000_0001_A000_0001));
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("level_3", 1'b0, 32'h0000_0003);
    din_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    din_ready_i = 1'b0;
    checkOutput("din_drained", 128'(din_valid_o), 128'(0));

    // Core returns two words; software reads them back in order
    @(negedge clk_i); dout_valid_i = 1'b1; dout_i = x0;
    @(negedge clk_i); dout_i = x1;
    @(negedge clk_i); dout_valid_i = 1'b0; dout_i = '0;
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("level_out2", 1'b0, 32'h0002_0000);
    applyStimulus(1'b0, 8'h0C, 4'h0, 32'h0); checkResp("irq_nonempty", 1'b0, 32'h4);
    applyStimulus(1'b0, 8'h38, 4'h0, 32'h0); checkResp("dout0_lo", 1'b0, x0[31:0]);
    applyStimulus(1'b0, 8'h3C, 4'h0, 32'h0); checkResp("dout0_hi", 1'b0, x0[63:32]);
    applyStimulus(1'b0, 8'h38, 4'h0, 32'h0); checkResp("dout1_lo", 1'b0, x1[31:0]);
    applyStimulus(1'b0, 8'h3C, 4'h0, 32'h0); checkResp("dout1_hi", 1'b0, x1[63:32]);
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("level_out0", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h3C, 4'h0, 32'h0); checkResp("dout_empty", 1'b1, 32'h0);
    applyStimulus(1'b1, 8'h0C, 4'hF, 32'h4); checkResp("w1c_nonempty", 1'b0, 32'h0);

    // Decrypt with tag mismatch raises done and auth_fail
    applyStimulus(1'b1, 8'h08, 4'hF, 32'h3); checkResp("irq_en_wr", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h08, 4'h0, 32'h0); checkResp("irq_en_rd", 1'b0, 32'h3);
    applyStimulus(1'b1, 8'h00, 4'hF, 32'h3); checkResp("ctrl_dec", 1'b0, 32'h0);
    checkOutput("mode_dec", 128'(mode_o), 128'(1));
    busy_i = 1'b1; done_i = 1'b1; auth_i = 1'b0;
    @(negedge clk_i); busy_i = 1'b0; done_i = 1'b0;
    checkOutput("irq_delay", 128'(irq_o), 128'(0));
    @(negedge clk_i);
    checkOutput("irq_set", 128'(irq_o), 128'(1));
    applyStimulus(1'b0, 8'h0C, 4'h0, 32'h0); checkResp("irq_st3", 1'b0, 32'h3);
    applyStimulus(1'b0, 8'h04, 4'h0, 32'h0); checkResp("status_done", 1'b0, 32'h0000_002A);
    applyStimulus(1'b1, 8'h0C, 4'hF, 32'h3); checkResp("w1c_all", 1'b0, 32'h0);
    checkOutput("irq_still", 128'(irq_o), 128'(1));
    @(negedge clk_i);
    checkOutput("irq_clear", 128'(irq_o), 128'(0));
    applyStimulus(1'b0, 8'h0C, 4'h0, 32'h0); checkResp("irq_st0", 1'b0, 32'h0);

    // W1C in the same cycle as done_i: the hardware set wins
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h0C; be_i = 4'hF; wdata_i = 32'h3;
    cur_aid = ~cur_aid; aid_i = cur_aid; done_i = 1'b1; auth_i = 1'b1;
    #1 rsp_gnt = gnt_o;
    @(negedge clk_i);
    rsp_valid = rvalid_o; rsp_data = rdata_o; rsp_err = err_o; rsp_id = rid_o;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0; done_i = 1'b0; auth_i = 1'b0;
    checkResp("w1c_vs_done", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h0C, 4'h0, 32'h0); checkResp("irq_st_kept", 1'b0, 32'h1);
    applyStimulus(1'b0, 8'h04, 4'h0, 32'h0); checkResp("status_auth", 1'b0, 32'h0000_006A);

    // Reset mid-operation with words queued and a read in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h30, 4'hF, 32'hC000_0000 + i); checkResp("q_lo", 1'b0, 32'h0);
      applyStimulus(1'b1, 8'h34, 4'hF, 32'hD000_0000 + i); checkResp("q_hi", 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("level_q3", 1'b0, 32'h0000_0003);
    checkOutput("irq_pre_rst", 128'(irq_o), 128'(1));
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h40;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("mid_rst.rvalid", 128'(rvalid_o), 128'(0));
    checkOutput("mid_rst.din_valid", 128'(din_valid_o), 128'(0));
    req_i = 1'b0; addr_i = '0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst.rvalid", 128'(rvalid_o), 128'(0));
    checkOutput("post_rst.irq", 128'(irq_o), 128'(0));
    checkOutput("post_rst.dout_ready", 128'(dout_ready_o), 128'(1));
    applyStimulus(1'b0, 8'h40, 4'h0, 32'h0); checkResp("post_rst.level", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h08, 4'h0, 32'h0); checkResp("post_rst.irq_en", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h0C, 4'h0, 32'h0); checkResp("post_rst.irq_st", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h10, 4'h0, 32'h0); checkResp("post_rst.key0", 1'b0, 32'h0);
    applyStimulus(1'b0, 8'h04, 4'h0, 32'h0); checkResp("post_rst.status", 1'b0, 32'h0000_000A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
